// File: rtl/uart_tx_monitor_pkg.sv
// Shared types and constants for the UART TX console monitor.
// FSM state encoding and the ASCII end-of-test tokens the monitor watches for.
package uart_tx_monitor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        RECOVER
    } state_t;

    localparam logic [31:0] PASS_TOKEN = 32'h5041_5353;
    localparam logic [31:0] FAIL_TOKEN = 32'h4641_494C;

    // Oldest character lives in the top byte, so "PASS" reads left to right.
    function automatic logic [31:0] push_byte(input logic [31:0] hist, input logic [7:0] b);
        return {hist[23:0], b};
    endfunction

endpackage

// File: rtl/uart_tx_monitor_sync.sv
// Two-flop synchronizer for the asynchronous UART line.
// Resets to 1 so an idle-high line never looks like a start bit after reset.
module uart_tx_monitor_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta <= 1'b1;
            q_o  <= 1'b1;
        end else begin
            meta <= d_i;
            q_o  <= meta;
        end
    end

endmodule

// File: rtl/uart_tx_monitor.sv
// Passive 8N1 receiver that decodes the SoC console and flags PASS/FAIL tokens.
// Define UART_TX_MONITOR_DISPLAY_EN to echo characters and events to the simulator console.
module uart_tx_monitor
    import uart_tx_monitor_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             uart_tx_i,
    output logic             rx_valid_o,
    output logic [7:0]       rx_data_o,
    output logic             frame_err_o,
    output logic [CNT_W-1:0] char_count_o,
    output logic             pass_o,
    output logic             fail_o
);

    localparam int unsigned     TMR_W     = 16;
    localparam logic [TMR_W-1:0] HALF_LOAD = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMR_W-1:0] FULL_LOAD = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             line;
    state_t           state, state_next;
    logic [TMR_W-1:0] tmr, tmr_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shift_q, shift_next;
    logic             good_stop, bad_stop;
    logic             tmr_done;
    logic [31:0]      history;
    logic [31:0]      new_hist;
    logic             pass_hit, fail_hit, frozen;

    uart_tx_monitor_sync u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (uart_tx_i),
        .q_o    (line)
    );

    assign tmr_done = (tmr == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            tmr     <= '0;
            bit_idx <= '0;
            shift_q <= '0;
        end else begin
            state   <= state_next;
            tmr     <= tmr_next;
            bit_idx <= bit_idx_next;
            shift_q <= shift_next;
        end
    end

    // The START timer runs half a bit so every later sample lands mid-bit.
    always_comb begin
        state_next   = state;
        tmr_next     = tmr;
        bit_idx_next = bit_idx;
        shift_next   = shift_q;
        good_stop    = 1'b0;
        bad_stop     = 1'b0;
        case (state)
            IDLE: begin
                if (!line) begin
                    state_next = START;
                    tmr_next   = HALF_LOAD;
                end
            end
            START: begin
                if (tmr_done) begin
                    if (!line) begin
                        state_next   = DATA;
                        tmr_next     = FULL_LOAD;
                        bit_idx_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    tmr_next = tmr - TMR_W'(1);
                end
            end
            DATA: begin
                if (tmr_done) begin
                    shift_next = {line, shift_q[7:1]};
                    tmr_next   = FULL_LOAD;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    tmr_next = tmr - TMR_W'(1);
                end
            end
            STOP: begin
                if (tmr_done) begin
                    if (line) begin
                        good_stop  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        bad_stop   = 1'b1;
                        state_next = RECOVER;
                    end
                end else begin
                    tmr_next = tmr - TMR_W'(1);
                end
            end
            RECOVER: begin
                if (line) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_valid_o   <= 1'b0;
            frame_err_o  <= 1'b0;
            rx_data_o    <= '0;
            char_count_o <= '0;
        end else begin
            rx_valid_o  <= good_stop;
            frame_err_o <= bad_stop;
            if (good_stop) begin
                rx_data_o <= shift_q;
                if (char_count_o != CNT_MAX) begin
                    char_count_o <= char_count_o + CNT_W'(1);
                end
            end
        end
    end

    assign new_hist = push_byte(history, rx_data_o);
    assign pass_hit = rx_valid_o && (new_hist == PASS_TOKEN);
    assign fail_hit = rx_valid_o && (new_hist == FAIL_TOKEN);
    assign frozen   = pass_o || fail_o;

    // Whichever token shows up first wins; the other is locked out until reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            history <= '0;
            pass_o  <= 1'b0;
            fail_o  <= 1'b0;
        end else begin
            if (rx_valid_o) begin
                history <= new_hist;
            end
            if (!frozen) begin
                if (pass_hit) begin
                    pass_o <= 1'b1;
                end else if (fail_hit) begin
                    fail_o <= 1'b1;
                end
            end
        end
    end

`ifdef UART_TX_MONITOR_DISPLAY_EN
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            if (rx_valid_o) begin
                $write("%c", rx_data_o);
            end
            if (frame_err_o) begin
                $display("uart_tx_monitor: frame error at %0t", $time);
            end
            if (!frozen && pass_hit) begin
                $display("uart_tx_monitor: PASS token at %0t", $time);
            end
            if (!frozen && !pass_hit && fail_hit) begin
                $display("uart_tx_monitor: FAIL token at %0t", $time);
            end
        end
    end
`else
    // Console echo is compiled out; port behaviour is unchanged.
`endif

endmodule

// File: doc/uart_tx_monitor.md
UART_TX_MONITOR -- requirements
Module: uart_tx_monitor

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clk_i cycles per UART bit; legal values are 4 to 65535.
REQ-002 SHALL have parameter CNT_W, default 16, width of char_count_o.
REQ-003 SHALL have port clk_i, input, 1, the single clock for the block.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port uart_tx_i, input, 1, serial line driven by the SoC uart_tx, idle high, 8N1 format.
REQ-006 SHALL have port rx_valid_o, output, 1, one-cycle strobe marking a good character.
REQ-007 SHALL have port rx_data_o, output, 8, the received byte; valid while rx_valid_o is high and held afterwards.
REQ-008 SHALL have port frame_err_o, output, 1, one-cycle strobe on a bad stop bit.
REQ-009 SHALL have port char_count_o, output, CNT_W, count of good characters; saturates at its maximum.
REQ-010 SHALL have port pass_o, output, 1, sticky; set when the PASS token is received.
REQ-011 SHALL have port fail_o, output, 1, sticky; set when the FAIL token is received.

Function
REQ-012 SHALL pass uart_tx_i through a 2-flop synchronizer; all later logic uses only the synchronized value.
REQ-013 SHALL implement the FSM states IDLE, START, DATA, STOP and RECOVER.
REQ-014 SHALL move IDLE->START on a synchronized low and load the bit counter with CLKS_PER_BIT/2-1.
REQ-015 SHALL, in START, sample the line when the counter expires: low -> DATA, high (glitch) -> IDLE with no strobe.
REQ-016 SHALL, in DATA, sample every CLKS_PER_BIT cycles and shift the bits in LSB first; after 8 bits go to STOP.
REQ-017 SHALL, in STOP, sample after CLKS_PER_BIT cycles: high -> pulse rx_valid_o on the next cycle and go to IDLE.
REQ-018 SHALL, in STOP, on a low sample pulse frame_err_o for one cycle, leave rx_data_o and the count unchanged, and go to RECOVER.
REQ-019 SHALL stay in RECOVER until the synchronized line is high, then go to IDLE.
REQ-020 SHALL assert rx_valid_o exactly 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the start-bit falling edge at the pin.
REQ-021 SHALL allow a start bit that begins in the cycle after the return to IDLE, so back-to-back frames need no idle bit.
REQ-022 SHALL shift each good character into a 4-byte history register; bad frames do not enter the history.
REQ-023 SHALL compare the history with PASS_TOKEN ("PASS") and FAIL_TOKEN ("FAIL") on the cycle after rx_valid_o.
REQ-024 SHALL set only the first of pass_o/fail_o to match; once either is set, both are frozen until reset.
REQ-025 SHALL increment char_count_o on rx_valid_o and saturate at 2^CNT_W-1.

Reset
REQ-026 SHALL, while rst_ni is low, force the FSM to IDLE and clear every output, the history, the counters, and both synchronizer flops (reset to 1).
REQ-027 SHALL discard any partial frame when reset occurs mid-frame and raise no strobe for it.
REQ-028 SHALL start operation on the first clk_i edge after rst_ni deasserts; deassertion is synchronized externally.

Configuration
REQ-029 SHALL, when UART_TX_MONITOR_DISPLAY_EN is defined, $write each good character to the simulator console, and $display the time on frame errors and on pass/fail.
REQ-030 SHALL, when UART_TX_MONITOR_DISPLAY_EN is undefined, have no system tasks, stay synthesizable, and keep port behaviour identical.

Structure
REQ-031 SHALL place the FSM state enum, PASS_TOKEN and FAIL_TOKEN (32-bit ASCII constants) in the package uart_tx_monitor_pkg.
REQ-032 SHALL place the 2-flop synchronizer in the sub-module uart_tx_monitor_sync, with an asynchronous active-low reset value of 1.

Verification (CLKS_PER_BIT=16)
REQ-033 SHALL check: send 0x55 -> rx_valid_o at cycle 155 after the falling edge, rx_data_o=0x55, char_count_o=1.
REQ-034 SHALL check: send "xxPASS" back-to-back -> 6 strobes, pass_o=1 after the 6th, fail_o=0; then send "FAIL" -> fail_o stays 0.
REQ-035 SHALL check: send 0xA3 with the stop bit held low -> one frame_err_o pulse, no rx_valid_o, count unchanged; after the line goes high, 0x0F is received correctly.
REQ-036 SHALL check: a 5-cycle low glitch on idle line -> no strobes, FSM back in IDLE.
REQ-037 SHALL check: rst_ni low in the middle of the DATA bits of 0xFF -> no strobe; after reset release, 0x12 is received correctly.
REQ-038 SHALL check: CNT_W=2 with 5 characters sent -> char_count_o saturates at 3.
